// File: rtl/sqrt_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : sqrt_arbiter_if
// Brief   : Requester and response channel bundle for sqrt_arbiter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sqrt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [15:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

`default_nettype wire

// File: rtl/sqrt_arbiter.sv
//------------------------------------------------------------------------------
// Module  : sqrt_arbiter
// Brief   : Round-robin sharing of one combinational 32-bit sqrt unit among
//           NUM_REQ requesters. Optional macro SQRT_ARB_STATS_EN adds
//           op_count / last_grant outputs.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sqrt_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int SQRT_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sqrt_arbiter_if.slave        bus,
  output logic [31:0]          sqrt_in,
  input  logic [15:0]          sqrt_out,
  output logic                 busy
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [ID_W-1:0]      last_grant
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ ||
      SQRT_LAT < 1 || SQRT_LAT > 15) begin : g_param_err
    $error("sqrt_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0]      c_cnt_init = 4'(SQRT_LAT - 1);
  localparam logic [ID_W-1:0] c_ptr_rst  = ID_W'(NUM_REQ - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_ptr;
  logic [3:0]           r_cnt;
  logic [31:0]          r_sqrt_in;
  logic                 r_rsp_valid;
  logic [15:0]          r_rsp_data;
  logic [ID_W-1:0]      r_rsp_id;

  logic                 w_gnt_found;
  logic [ID_W-1:0]      w_gnt_id;
  logic [31:0]          w_gnt_data;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic                 w_accept;
  logic                 w_wait_done;
  logic                 w_rsp_done;

  // Candidate index (ptr + off) mod NUM_REQ, off in 1..NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_gnt_found && bus.req_valid[rr_idx(r_ptr, i)]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = rr_idx(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_id == ID_W'(k)) w_gnt_data = bus.req_data[32*k +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_wait_done = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_found) begin
          w_req_ready[w_gnt_id] = 1'b1;
          w_accept              = 1'b1;
          w_state_nxt           = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_wait_done = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/response registers; sqrt_in keeps the last operand after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= c_ptr_rst;
      r_cnt       <= 4'd0;
      r_sqrt_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_accept) begin
        r_sqrt_in <= w_gnt_data;
        r_rsp_id  <= w_gnt_id;
        r_ptr     <= w_gnt_id;
        r_cnt     <= c_cnt_init;
      end
      if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_wait_done) begin
        r_rsp_data  <= sqrt_out;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_done) r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign sqrt_in       = r_sqrt_in;
  assign busy          = (r_state != ST_IDLE);

`ifdef SQRT_ARB_STATS_EN
  logic [15:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_op_count <= '0;
    else if (w_rsp_done) r_op_count <= r_op_count + 16'd1;
  end

  assign op_count   = r_op_count;
  assign last_grant = r_ptr;
`endif

endmodule

`default_nettype wire
